// File: rtl/sha1_pad.sv
// sha1_pad: SHA-1 message padder. Takes a byte stream and emits padded 512-bit blocks
//   (0x80, zero fill, 64-bit big-endian bit length) in the core's message_in word order.
// Latency: block_valid 1 cycle after the 64th non-last byte is accepted, 2 cycles after
//   the last byte; a length-only block is valid 2 cycles after the previous handshake.
// Backpressure: in_ready is low while a block is padded, built or presented; the presented
//   block and block_last are held stable until block_valid & block_ready.
// Ports: clk/reset (sync, active-high); in_data/in_valid/in_last/in_ready byte input;
//   block/block_valid/block_ready/block_last block output (word i at [32i+31:32i],
//   byte 4i is its MSB); busy = message in progress.
// Config: define SHA1_PAD_LEN64_EN for a 61-bit byte counter and full 64-bit length
//   field; otherwise the counter is 29 bits and length bits 63:32 are zero.
module sha1_pad (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] block,
  output logic         block_valid,
  input  logic         block_ready,
  output logic         block_last,
  output logic         busy
);

`ifdef SHA1_PAD_LEN64_EN
  localparam int CW = 61;
`else
  localparam int CW = 29;
`endif

  typedef enum logic [1:0] {S_FILL, S_PAD, S_EMIT, S_LEN_BUILD} state_t;

  state_t           state_q, state_d;
  logic [63:0][7:0] mem_q;          // mem_q[k] is message byte k of the current block
  logic [6:0]       p_q;            // fill pointer, 0..64
  logic [CW-1:0]    cnt_q;          // message byte count
  logic             len_pending_q;  // length must go in a second block
  logic             pad_full_q;     // last data block was full, so 0x80 opens the next
  logic             block_last_q;
  logic [63:0]      len_bits;
  logic             in_fire, blk_fire;

`ifdef SHA1_PAD_LEN64_EN
  assign len_bits = {cnt_q, 3'b000};
`else
  assign len_bits = {32'd0, cnt_q, 3'b000};
`endif

  assign in_ready    = !reset && (state_q == S_FILL) && (p_q < 7'd64);
  assign in_fire     = in_valid && in_ready;
  assign block_valid = (state_q == S_EMIT);
  assign blk_fire    = block_valid && block_ready;
  assign block_last  = block_last_q;
  assign busy        = (state_q != S_FILL) || (p_q != 7'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL: begin
        if (in_fire) begin
          // A last byte that also fills the block still goes through PAD.
          if (in_last)              state_d = S_PAD;
          else if (p_q == 7'd63)    state_d = S_EMIT;
        end
      end
      S_PAD:       state_d = S_EMIT;
      S_EMIT:      if (blk_fire) state_d = len_pending_q ? S_LEN_BUILD : S_FILL;
      S_LEN_BUILD: state_d = S_EMIT;
      default:     state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FILL;
      mem_q         <= '0;
      p_q           <= 7'd0;
      cnt_q         <= '0;
      len_pending_q <= 1'b0;
      pad_full_q    <= 1'b0;
      block_last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_FILL: begin
          if (in_fire) begin
            mem_q[p_q[5:0]] <= in_data;
            p_q             <= p_q + 7'd1;
            cnt_q           <= cnt_q + CW'(1);
          end
        end
        S_PAD: begin
          // p==64 matches no byte, leaving a full data block untouched.
          for (int k = 0; k < 64; k++) begin
            if (k == int'(p_q))
              mem_q[k] <= 8'h80;
            else if (k > int'(p_q))
              mem_q[k] <= (k >= 56 && p_q <= 7'd55) ? len_bits[8*(63-k) +: 8] : 8'h00;
          end
          block_last_q  <= (p_q <= 7'd55);
          len_pending_q <= (p_q > 7'd55);
          pad_full_q    <= (p_q == 7'd64);
        end
        S_EMIT: begin
          if (blk_fire) begin
            p_q          <= 7'd0;
            block_last_q <= 1'b0;
            if (!len_pending_q && block_last_q) cnt_q <= '0;
          end
        end
        S_LEN_BUILD: begin
          for (int k = 0; k < 64; k++) begin
            if (k >= 56)
              mem_q[k] <= len_bits[8*(63-k) +: 8];
            else if (k == 0 && pad_full_q)
              mem_q[k] <= 8'h80;
            else
              mem_q[k] <= 8'h00;
          end
          block_last_q  <= 1'b1;
          len_pending_q <= 1'b0;
          pad_full_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Byte k lands in word k/4; byte 4i is the most significant byte of word i.
  always_comb begin
    block = '0;
    for (int k = 0; k < 64; k++)
      block[32*(k/4) + 8*(3-(k%4)) +: 8] = mem_q[k];
  end

endmodule

// File: tb/tb_sha1_pad.sv
module tb_sha1_pad;
  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [511:0] block;
  logic         block_valid;
  logic         block_ready;
  logic         block_last;
  logic         busy;

  always #5 clk = ~clk;

  sha1_pad dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .block(block),
    .block_valid(block_valid), .block_ready(block_ready),
    .block_last(block_last), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]   msg_q[$];
  logic [511:0] exp_q[$];
  logic         exp_l_q[$];
  logic [511:0] got_q[$];
  logic         got_l_q[$];
  int           hs_q[$];
  int           first_valid, last_acc, acc63;
  int           rdy_in_emit = 0;

  typedef struct {
    int          len;
    int          kind;   // 0 zeros, 1 ramp 0,1,2.., 2 "abc.."
    int          nblk;
    logic [31:0] w0f, w14f, w15f, w0l, w15l;
    int          lat;    // first block_valid relative to last byte (or 64th byte if longer)
    int          gap;    // handshake-to-handshake for two blocks at full rate, 0 = skip
  } vec_t;

  vec_t vt[5];
  int   bl[10] = '{1, 55, 56, 57, 63, 64, 65, 119, 120, 128};

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: standard SHA-1 padding of the whole message, then split into 64-byte blocks.
  task automatic build_exp();
    logic [7:0]   pb[$];
    logic [63:0]  bits;
    logic [511:0] blk;
    int           nb;
    pb = msg_q;
    pb.push_back(8'h80);
    while (pb.size() % 64 != 56) pb.push_back(8'h00);
    bits = 64'(msg_q.size()) * 64'd8;
`ifndef SHA1_PAD_LEN64_EN
    bits[63:32] = 32'd0;
`endif
    for (int i = 7; i >= 0; i--) pb.push_back(bits[8*i +: 8]);
    exp_q.delete();
    exp_l_q.delete();
    nb = pb.size() / 64;
    for (int b = 0; b < nb; b++) begin
      blk = '0;
      for (int w = 0; w < 16; w++)
        blk[32*w +: 32] = {pb[64*b+4*w], pb[64*b+4*w+1], pb[64*b+4*w+2], pb[64*b+4*w+3]};
      exp_q.push_back(blk);
      exp_l_q.push_back(b == nb - 1);
    end
  endtask

  // Streams msg_q with random valid/ready; collects blocks until the model's count arrives.
  task automatic run_stream(input int vpct, input int rpct, input int max_cyc);
    int idx;
    int c;
    idx = 0;
    c = 0;
    first_valid = -1;
    last_acc = -1;
    acc63 = -1;
    got_q.delete();
    got_l_q.delete();
    hs_q.delete();
    while (got_q.size() < exp_q.size() && c < max_cyc) begin
      if (idx < msg_q.size() && $urandom_range(99) < vpct) begin
        in_valid = 1'b1;
        in_data  = msg_q[idx];
        in_last  = (idx == msg_q.size() - 1);
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
      end
      block_ready = ($urandom_range(99) < rpct);
      #1;
      if (in_valid && in_ready) begin
        if (idx == 63) acc63 = c;
        if (idx == msg_q.size() - 1) last_acc = c;
        idx++;
      end
      if (block_valid && in_ready) rdy_in_emit++;
      if (block_valid) begin
        if (first_valid < 0) first_valid = c;
        if (block_ready) begin
          got_q.push_back(block);
          got_l_q.push_back(block_last);
          hs_q.push_back(c);
        end
      end
      @(posedge clk);
      #1;
      c++;
    end
    in_valid    = 1'b0;
    in_last     = 1'b0;
    block_ready = 1'b0;
  endtask

  task automatic compare_blocks(input string tag);
    check($sformatf("%s_nblk", tag), got_q.size(), exp_q.size());
    for (int b = 0; b < got_q.size() && b < exp_q.size(); b++) begin
      check($sformatf("%s_blk%0d", tag, b), got_q[b], exp_q[b]);
      check($sformatf("%s_last%0d", tag, b), got_l_q[b], exp_l_q[b]);
    end
  endtask

  // Drives msg_q one byte per cycle; caller guarantees the DUT is idle in FILL.
  task automatic send_full();
    for (int i = 0; i < msg_q.size(); i++) begin
      in_valid = 1'b1;
      in_data  = msg_q[i];
      in_last  = (i == msg_q.size() - 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      if (block_valid) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic load_abc();
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
    build_exp();
  endtask

  initial begin
    bit           ok;
    int           bad;
    logic [511:0] held;

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; block_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_block", block, 512'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", in_ready, 1'b1);
    check("post_reset_valid", block_valid, 1'b0);
    check("post_reset_last", block_last, 1'b0);
    check("post_reset_busy", busy, 1'b0);

    vt[0] = '{3,  2, 1, 32'h61626380, 32'h0,        32'h18,       32'h61626380, 32'h18,  2, 0};
    vt[1] = '{55, 0, 1, 32'h0,        32'h0,        32'h1B8,      32'h0,        32'h1B8, 2, 0};
    vt[2] = '{56, 0, 2, 32'h0,        32'h80000000, 32'h0,        32'h0,        32'h1C0, 2, 2};
    vt[3] = '{64, 1, 2, 32'h00010203, 32'h38393A3B, 32'h3C3D3E3F, 32'h80000000, 32'h200, 2, 2};
    vt[4] = '{70, 1, 2, 32'h00010203, 32'h38393A3B, 32'h3C3D3E3F, 32'h40414243, 32'h230, 1, 8};

    for (int v = 0; v < 5; v++) begin
      msg_q.delete();
      for (int i = 0; i < vt[v].len; i++)
        msg_q.push_back(vt[v].kind == 0 ? 8'h00 : vt[v].kind == 1 ? 8'(i) : 8'h61 + 8'(i));
      build_exp();
      run_stream(100, 100, 500);
      compare_blocks($sformatf("vec%0d", v));
      check($sformatf("vec%0d_nblk_tbl", v), got_q.size(), vt[v].nblk);
      if (got_q.size() == vt[v].nblk) begin
        check($sformatf("vec%0d_w0f", v),  got_q[0][31:0],    vt[v].w0f);
        check($sformatf("vec%0d_w14f", v), got_q[0][479:448], vt[v].w14f);
        check($sformatf("vec%0d_w15f", v), got_q[0][511:480], vt[v].w15f);
        check($sformatf("vec%0d_w0l", v),  got_q[vt[v].nblk-1][31:0],    vt[v].w0l);
        check($sformatf("vec%0d_w15l", v), got_q[vt[v].nblk-1][511:480], vt[v].w15l);
        check($sformatf("vec%0d_lastf", v), got_l_q[0], vt[v].nblk == 1);
        if (vt[v].gap != 0)
          check($sformatf("vec%0d_gap", v), hs_q[1] - hs_q[0], vt[v].gap);
      end
      check($sformatf("vec%0d_lat", v),
            first_valid - (vt[v].len > 64 ? acc63 : last_acc), vt[v].lat);
      check($sformatf("vec%0d_idle_rdy", v), in_ready, 1'b1);
      check($sformatf("vec%0d_idle_busy", v), busy, 1'b0);
    end

    for (int m = 0; m < 30; m++) begin
      int len;
      len = ($urandom_range(2) == 0) ? bl[$urandom_range(9)] : $urandom_range(1, 200);
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
      build_exp();
      run_stream($urandom_range(30, 100), $urandom_range(20, 100), 4000);
      compare_blocks($sformatf("rand%0d_len%0d", m, len));
    end
    check("in_ready_while_valid", rdy_in_emit, 0);

    // Backpressure on "abc".
    load_abc();
    send_full();
    check("bp_pad_valid", block_valid, 1'b0);
    wait_valid(10, ok);
    check("bp_valid_seen", ok, 1'b1);
    held = block;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!block_valid || block !== held || in_ready || !busy || !block_last) bad++;
      @(posedge clk);
      #1;
    end
    check("bp_hold_stable", bad, 0);
    check("bp_block", held, exp_q[0]);
    block_ready = 1'b1;
    @(posedge clk);
    #1;
    block_ready = 1'b0;
    check("bp_release_in_ready", in_ready, 1'b1);
    check("bp_release_valid", block_valid, 1'b0);
    check("bp_release_busy", busy, 1'b0);

    // Reset after 30 bytes, then "abc" must come out as if fresh.
    msg_q.delete();
    for (int i = 0; i < 30; i++) msg_q.push_back(8'($urandom));
    send_full();
    check("mid_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_reset_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_after_busy", busy, 1'b0);
    check("mid_after_in_ready", in_ready, 1'b1);
    load_abc();
    run_stream(100, 100, 200);
    compare_blocks("rst_abc");
    if (got_q.size() > 0) check("rst_abc_w15", got_q[0][511:480], 32'h18);

    // Reset while a block is presented.
    load_abc();
    send_full();
    wait_valid(10, ok);
    check("emit_rst_valid_seen", ok, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("emit_rst_valid", block_valid, 1'b0);
    check("emit_rst_busy", busy, 1'b0);
    check("emit_rst_last", block_last, 1'b0);
    check("emit_rst_block", block, 512'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("emit_rst_in_ready", in_ready, 1'b1);
    run_stream(100, 100, 200);
    compare_blocks("post_rst_abc");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
